trng_postproc: RTL

//  Downstream consumer of the ring-oscillator raw entropy bit. Synchronises the

---
 rtl/trng_postproc_if.sv | 14 +
 rtl/trng_postproc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/trng_postproc_if.sv
// Output port of the TRNG post-processor: packed word plus valid/ready handshake.
//   data_out    packed random word (producer -> consumer)
//   data_valid  data_out holds an unconsumed word (producer -> consumer)
//   data_ready  consumer takes the word when data_valid & data_ready
interface trng_postproc_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/trng_postproc.sv
// TRNG post-processor: synchronises the ring-oscillator bit, decimates it,
// debiases it with a von Neumann corrector, packs bits into words and offers
// them on a valid/ready port. A repetition-count health test blocks output.
//   clk          system clock
//   rst_n        asynchronous active-low reset (released synchronously)
//   raw_bit      ring-oscillator output, asynchronous to clk
//   en           1 = collect entropy, 0 = hold sampling idle
//   out_if       word output (data_out / data_valid / data_ready)
//   overflow     sticky: a completed word was dropped because the slot was full
//   health_fail  sticky: repetition-count test tripped
//
// Von Neumann FSM
//   state     | meaning
//   ST_FIRST  | waiting for the first sample of a pair
//   ST_SECOND | b0 latched, next sample completes the pair
module trng_postproc #(
    parameter int SYNC_STAGES = 2,
    parameter int SAMPLE_DIV  = 4,
    parameter int WORD_W      = 8,
    parameter int REP_LIMIT   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            raw_bit,
    input  logic            en,
    trng_postproc_if.master out_if,
    output logic            overflow,
    output logic            health_fail
);
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int BIT_W = $clog2(WORD_W);
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    typedef enum logic {ST_FIRST = 1'b0, ST_SECOND = 1'b1} vn_state_e;

    logic [1:0]             rst_sync_q;
    logic                   rst_int_n;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DIV_W-1:0]       div_cnt_q, div_cnt_d;
    vn_state_e              state_q, state_d;
    logic                   b0_q, b0_d;
    logic [WORD_W-1:0]      shreg_q, shreg_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]      data_out_q, data_out_d;
    logic                   data_valid_q, data_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   health_fail_q, health_fail_d;
    logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
    logic                   prev_q, prev_d;

    logic                   s_bit, strobe, smp, emit, emit_bit;
    logic [WORD_W-1:0]      word_next;
    logic                   word_done, slot_free;

    // Assertion is immediate; release is aligned to clk so all flops leave
    // reset on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    assign s_bit  = sync_q[SYNC_STAGES-1];
    assign strobe = en && (div_cnt_q == DIV_W'(SAMPLE_DIV - 1));
    // A tripped health test freezes debias and packing; sampling for the
    // health test itself keeps running.
    assign smp    = strobe && !health_fail_q;

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            sync_q        <= '0;
            div_cnt_q     <= '0;
            state_q       <= ST_FIRST;
            b0_q          <= 1'b0;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            overflow_q    <= 1'b0;
            health_fail_q <= 1'b0;
            rep_cnt_q     <= '0;
            prev_q        <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            div_cnt_q     <= div_cnt_d;
            state_q       <= state_d;
            b0_q          <= b0_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            overflow_q    <= overflow_d;
            health_fail_q <= health_fail_d;
            rep_cnt_q     <= rep_cnt_d;
            prev_q        <= prev_d;
        end
    end

    // FSM next state; en=0 throws away a half-collected pair.
    always_comb begin
        state_d = state_q;
        b0_d    = b0_q;
        if (!en) begin
            state_d = ST_FIRST;
        end else if (smp) begin
            case (state_q)
                ST_FIRST: begin
                    b0_d    = s_bit;
                    state_d = ST_SECOND;
                end
                default: state_d = ST_FIRST;
            endcase
        end
    end

    // FSM output: 10 -> 1, 01 -> 0, 00/11 -> nothing.
    always_comb begin
        emit     = smp && (state_q == ST_SECOND) && (s_bit != b0_q);
        emit_bit = b0_q;
    end

    assign word_next = {shreg_q[WORD_W-2:0], emit_bit};
    assign word_done = emit && (bit_cnt_q == BIT_W'(WORD_W - 1));
    assign slot_free = !data_valid_q || out_if.data_ready;

    always_comb begin
        sync_d        = {sync_q[SYNC_STAGES-2:0], raw_bit};
        div_cnt_d     = '0;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        overflow_d    = overflow_q;
        health_fail_d = health_fail_q;
        rep_cnt_d     = rep_cnt_q;
        prev_d        = prev_q;

        if (en && (div_cnt_q != DIV_W'(SAMPLE_DIV - 1)))
            div_cnt_d = div_cnt_q + 1'b1;

        if (data_valid_q && out_if.data_ready)
            data_valid_d = 1'b0;

        if (emit) begin
            shreg_d   = word_next;
            bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
            if (word_done) begin
                if (slot_free) begin
                    data_out_d   = word_next;
                    data_valid_d = 1'b1;
                end else begin
                    overflow_d   = 1'b1;
                end
            end
        end

        // rep_cnt starts at 0, so the first sample after reset counts as 1
        // whichever value it has.
        if (strobe) begin
            prev_d = s_bit;
            if (s_bit != prev_q)
                rep_cnt_d = REP_W'(1);
            else if (rep_cnt_q != REP_W'(REP_LIMIT))
                rep_cnt_d = rep_cnt_q + 1'b1;
            if (rep_cnt_d == REP_W'(REP_LIMIT))
                health_fail_d = 1'b1;
        end

        if (health_fail_q)
            data_valid_d = 1'b0;
    end

    assign out_if.data_out   = data_out_q;
    assign out_if.data_valid = data_valid_q;
    assign overflow          = overflow_q;
    assign health_fail       = health_fail_q;
endmodule
